// File: rtl/tlb_unit_if.sv
// CP0/pipeline <-> TLB bundle: two translation ports, tlbp probe, tlbr read, tlbwi write.
// The master side issues requests; the TLB (slave) returns registered results.
interface tlb_unit_if #(
    parameter int TLBNUM = 16
);
    localparam int IDXW = $clog2(TLBNUM);

    logic            s0_req;
    logic [19:0]     s0_vaddr;
    logic [7:0]      s0_asid;
    logic            s0_rvalid;
    logic            s0_found;
    logic [IDXW-1:0] s0_index;
    logic [19:0]     s0_pfn;
    logic [2:0]      s0_c;
    logic            s0_d;
    logic            s0_v;

    logic            s1_req;
    logic [19:0]     s1_vaddr;
    logic [7:0]      s1_asid;
    logic            s1_rvalid;
    logic            s1_found;
    logic [IDXW-1:0] s1_index;
    logic [19:0]     s1_pfn;
    logic [2:0]      s1_c;
    logic            s1_d;
    logic            s1_v;

    logic            tlbp_req;
    logic [31:0]     tlbp_entryhi;
    logic            tlbp_wen;
    logic [31:0]     tlbp_index;

    logic            tlbr_req;
    logic [IDXW-1:0] tlb_index;
    logic            tlbr_wen;
    logic [77:0]     tlbr_entry;

    logic            tlbwi_we;
    logic [77:0]     tlbwi_entry;

    modport master (
        output s0_req, s0_vaddr, s0_asid,
        input  s0_rvalid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        output s1_req, s1_vaddr, s1_asid,
        input  s1_rvalid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        output tlbp_req, tlbp_entryhi,
        input  tlbp_wen, tlbp_index,
        output tlbr_req, tlb_index,
        input  tlbr_wen, tlbr_entry,
        output tlbwi_we, tlbwi_entry
    );

    modport slave (
        input  s0_req, s0_vaddr, s0_asid,
        output s0_rvalid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        input  s1_req, s1_vaddr, s1_asid,
        output s1_rvalid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        input  tlbp_req, tlbp_entryhi,
        output tlbp_wen, tlbp_index,
        input  tlbr_req, tlb_index,
        output tlbr_wen, tlbr_entry,
        input  tlbwi_we, tlbwi_entry
    );
endinterface

// File: rtl/tlb_unit.sv
// Fully associative TLB with two translation ports plus tlbp/tlbr/tlbwi, all results registered.
// Searches read the array before this cycle's write lands, so a write is seen one cycle later.

module tlb_search #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic [TLBNUM-1:0][77:0] entries,
    input  logic [18:0]             vpn2,
    input  logic [7:0]              asid,
    output logic                    found,
    output logic [IDXW-1:0]         idx
);
    logic [TLBNUM-1:0] hit;

    for (genvar i = 0; i < TLBNUM; i++) begin : g_cmp
        assign hit[i] = (entries[i][77:59] == vpn2) &&
                        (entries[i][50] || (entries[i][58:51] == asid));
    end

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hit[i]) idx = IDXW'(i);
        end
    end

    assign found = |hit;
endmodule

module tlb_unit #(
    parameter int TLBNUM = 16
) (
    input  logic      clk,
    input  logic      rst,
    tlb_unit_if.slave bus
);
    localparam int IDXW  = $clog2(TLBNUM);
    localparam int NXLAT = 2;
    localparam int NSRCH = NXLAT + 1;

    typedef struct packed {
        logic            found;
        logic [IDXW-1:0] idx;
        logic [19:0]     pfn;
        logic [2:0]      c;
        logic            d;
        logic            v;
    } xlat_t;

    logic [TLBNUM-1:0][77:0] entries_q, entries_d;
    logic [3:0]              vld_q, vld_d;
    xlat_t [NXLAT-1:0]       xlat_q, xlat_d;
    logic [31:0]             tlbp_index_q, tlbp_index_d;
    logic [77:0]             tlbr_entry_q, tlbr_entry_d;

    logic [NXLAT-1:0]            x_req;
    logic [NXLAT-1:0][19:0]      x_vaddr;
    logic [NSRCH-1:0][18:0]      srch_vpn2;
    logic [NSRCH-1:0][7:0]       srch_asid;
    logic [NSRCH-1:0]            srch_found;
    logic [NSRCH-1:0][IDXW-1:0]  srch_idx;
    logic                        unused_ehi;

    assign x_req     = {bus.s1_req, bus.s0_req};
    assign x_vaddr   = {bus.s1_vaddr, bus.s0_vaddr};
    // Search slot NXLAT is the tlbp probe; only VPN2 and ASID of EntryHi take part.
    assign srch_vpn2 = {bus.tlbp_entryhi[31:13], bus.s1_vaddr[19:1], bus.s0_vaddr[19:1]};
    assign srch_asid = {bus.tlbp_entryhi[7:0], bus.s1_asid, bus.s0_asid};
    assign unused_ehi = ^bus.tlbp_entryhi[12:8];

    for (genvar g = 0; g < NSRCH; g++) begin : g_srch
        tlb_search #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_srch (
            .entries (entries_q),
            .vpn2    (srch_vpn2[g]),
            .asid    (srch_asid[g]),
            .found   (srch_found[g]),
            .idx     (srch_idx[g])
        );
    end

    function automatic xlat_t pick(input logic [77:0] e, input logic found,
                                   input logic [IDXW-1:0] idx, input logic odd);
        xlat_t r;
        r = '0;
        if (found) begin
            r.found = 1'b1;
            r.idx   = idx;
            {r.pfn, r.c, r.d, r.v} = odd ? e[24:0] : e[49:25];
        end
        return r;
    endfunction

    always_comb begin
        entries_d = entries_q;
        if (bus.tlbwi_we) entries_d[bus.tlb_index] = bus.tlbwi_entry;

        vld_d = {bus.tlbr_req, bus.tlbp_req, bus.s1_req, bus.s0_req};

        xlat_d = xlat_q;
        for (int p = 0; p < NXLAT; p++) begin
            if (x_req[p]) begin
                xlat_d[p] = pick(entries_q[srch_idx[p]], srch_found[p], srch_idx[p], x_vaddr[p][0]);
            end
        end

        tlbp_index_d = tlbp_index_q;
        if (bus.tlbp_req) begin
            tlbp_index_d = srch_found[NXLAT] ? 32'(srch_idx[NXLAT]) : 32'h8000_0000;
        end

        tlbr_entry_d = tlbr_entry_q;
        if (bus.tlbr_req) tlbr_entry_d = entries_q[bus.tlb_index];
    end

    // Reset also squashes any request presented in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q    <= '0;
            vld_q        <= '0;
            xlat_q       <= '0;
            tlbp_index_q <= '0;
            tlbr_entry_q <= '0;
        end else begin
            entries_q    <= entries_d;
            vld_q        <= vld_d;
            xlat_q       <= xlat_d;
            tlbp_index_q <= tlbp_index_d;
            tlbr_entry_q <= tlbr_entry_d;
        end
    end

    assign bus.s0_rvalid  = vld_q[0];
    assign bus.s0_found   = xlat_q[0].found;
    assign bus.s0_index   = xlat_q[0].idx;
    assign bus.s0_pfn     = xlat_q[0].pfn;
    assign bus.s0_c       = xlat_q[0].c;
    assign bus.s0_d       = xlat_q[0].d;
    assign bus.s0_v       = xlat_q[0].v;

    assign bus.s1_rvalid  = vld_q[1];
    assign bus.s1_found   = xlat_q[1].found;
    assign bus.s1_index   = xlat_q[1].idx;
    assign bus.s1_pfn     = xlat_q[1].pfn;
    assign bus.s1_c       = xlat_q[1].c;
    assign bus.s1_d       = xlat_q[1].d;
    assign bus.s1_v       = xlat_q[1].v;

    assign bus.tlbp_wen   = vld_q[2];
    assign bus.tlbp_index = tlbp_index_q;
    assign bus.tlbr_wen   = vld_q[3];
    assign bus.tlbr_entry = tlbr_entry_q;
endmodule

// File: tb/tb_tlb_unit.sv
// Table of TLB operations replayed back to back; per-port queues hold the expected results.
module tb_tlb_unit;
    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;

    typedef enum logic [2:0] {OP_WR, OP_S0, OP_S1, OP_P, OP_R} op_e;

    typedef struct {
        op_e         op;
        logic [3:0]  idx;
        logic [77:0] ent;
        logic [19:0] va;
        logic [7:0]  asid;
        logic [31:0] ehi;
        logic [77:0] res;
    } vec_t;

    typedef struct {
        int          due;
        logic [77:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q0[$], q1[$], qp[$], qr[$];
    vec_t tbl[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tlb_unit_if #(.TLBNUM(TLBNUM)) bus ();
    tlb_unit #(.TLBNUM(TLBNUM)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [77:0] mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                       input logic g, input logic [24:0] p0, input logic [24:0] p1);
        return {vpn2, asid, g, p0, p1};
    endfunction

    function automatic logic [77:0] xh(input logic [3:0] idx, input logic [24:0] page);
        return 78'({1'b1, idx, page});
    endfunction

    function automatic vec_t vv(input op_e op, input logic [3:0] idx, input logic [77:0] ent,
                                input logic [19:0] va, input logic [7:0] asid,
                                input logic [31:0] ehi, input logic [77:0] res);
        vec_t v;
        v.op = op; v.idx = idx; v.ent = ent; v.va = va; v.asid = asid; v.ehi = ehi; v.res = res;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [77:0] act, input logic [77:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic clr();
        bus.s0_req = 0; bus.s1_req = 0; bus.tlbp_req = 0; bus.tlbr_req = 0; bus.tlbwi_we = 0;
    endtask

    task automatic idle();
        @(negedge clk); #1;
        clr();
    endtask

    task automatic drv(input vec_t v);
        @(negedge clk); #1;
        clr();
        case (v.op)
            OP_WR: begin bus.tlbwi_we = 1; bus.tlb_index = v.idx; bus.tlbwi_entry = v.ent; end
            OP_S0: begin
                bus.s0_req = 1; bus.s0_vaddr = v.va; bus.s0_asid = v.asid;
                q0.push_back('{due: cyc + 1, val: v.res});
            end
            OP_S1: begin
                bus.s1_req = 1; bus.s1_vaddr = v.va; bus.s1_asid = v.asid;
                q1.push_back('{due: cyc + 1, val: v.res});
            end
            OP_P: begin
                bus.tlbp_req = 1; bus.tlbp_entryhi = v.ehi;
                qp.push_back('{due: cyc + 1, val: v.res});
            end
            default: begin
                bus.tlbr_req = 1; bus.tlb_index = v.idx;
                qr.push_back('{due: cyc + 1, val: v.res});
            end
        endcase
    endtask

    // Scoreboard: every result must arrive exactly one cycle after its request.
    always @(negedge clk) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin
            chk("s0_rvalid", 78'(bus.s0_rvalid), 78'd1);
            chk("s0_result", 78'({bus.s0_found, bus.s0_index, bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v}), q0[0].val);
            void'(q0.pop_front());
        end else if (bus.s0_rvalid === 1'b1) chk("s0_unexpected_rvalid", 78'(bus.s0_rvalid), 78'd0);

        if (q1.size() > 0 && q1[0].due == cyc) begin
            chk("s1_rvalid", 78'(bus.s1_rvalid), 78'd1);
            chk("s1_result", 78'({bus.s1_found, bus.s1_index, bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v}), q1[0].val);
            void'(q1.pop_front());
        end else if (bus.s1_rvalid === 1'b1) chk("s1_unexpected_rvalid", 78'(bus.s1_rvalid), 78'd0);

        if (qp.size() > 0 && qp[0].due == cyc) begin
            chk("tlbp_wen", 78'(bus.tlbp_wen), 78'd1);
            chk("tlbp_index", 78'(bus.tlbp_index), qp[0].val);
            void'(qp.pop_front());
        end else if (bus.tlbp_wen === 1'b1) chk("tlbp_unexpected_wen", 78'(bus.tlbp_wen), 78'd0);

        if (qr.size() > 0 && qr[0].due == cyc) begin
            chk("tlbr_wen", 78'(bus.tlbr_wen), 78'd1);
            chk("tlbr_entry", bus.tlbr_entry, qr[0].val);
            void'(qr.pop_front());
        end else if (bus.tlbr_wen === 1'b1) chk("tlbr_unexpected_wen", 78'(bus.tlbr_wen), 78'd0);
    end

    initial begin
        logic [24:0] p0_3, p1_3, p0_29, p1_29, p0_7;
        logic [77:0] e3a, e3g, e29, e7;
        p0_3  = {20'h12345, 3'd3, 1'b1, 1'b1};
        p1_3  = {20'hABCDE, 3'd2, 1'b0, 1'b1};
        p0_29 = {20'h0F0F0, 3'd5, 1'b0, 1'b1};
        p1_29 = {20'h55555, 3'd7, 1'b1, 1'b1};
        p0_7  = {20'h00007, 3'd1, 1'b1, 1'b1};
        e3a = mk(19'h00200, 8'h05, 1'b0, p0_3, p1_3);
        e3g = mk(19'h00200, 8'h05, 1'b1, p0_3, p1_3);
        e29 = mk(19'h1ABCD, 8'h22, 1'b0, p0_29, p1_29);
        e7  = mk(19'h07777, 8'h01, 1'b1, p0_7, {20'h70000, 5'd0});

        tbl.push_back(vv(OP_WR, 4'd3, e3a, 0, 0, 0, 0));
        tbl.push_back(vv(OP_P,  0, 0, 0, 0, 32'h0040_0005, 78'h3));
        tbl.push_back(vv(OP_P,  0, 0, 0, 0, 32'h0040_0006, 78'h8000_0000));
        tbl.push_back(vv(OP_S1, 0, 0, 20'h00401, 8'h05, 0, xh(3, p1_3)));
        tbl.push_back(vv(OP_S1, 0, 0, 20'h00400, 8'h05, 0, xh(3, p0_3)));
        tbl.push_back(vv(OP_S0, 0, 0, 20'h00400, 8'h06, 0, 78'h0));
        tbl.push_back(vv(OP_S0, 0, 0, 20'h00401, 8'h05, 0, xh(3, p1_3)));
        tbl.push_back(vv(OP_WR, 4'd3, e3g, 0, 0, 0, 0));
        tbl.push_back(vv(OP_P,  0, 0, 0, 0, 32'h0040_0006, 78'h3));
        tbl.push_back(vv(OP_S0, 0, 0, 20'h00400, 8'h06, 0, xh(3, p0_3)));
        tbl.push_back(vv(OP_R,  4'd3, 0, 0, 0, 0, e3g));
        tbl.push_back(vv(OP_R,  4'd0, 0, 0, 0, 0, 78'h0));
        tbl.push_back(vv(OP_WR, 4'd2, e29, 0, 0, 0, 0));
        tbl.push_back(vv(OP_WR, 4'd9, e29, 0, 0, 0, 0));
        tbl.push_back(vv(OP_P,  0, 0, 0, 0, {19'h1ABCD, 5'h1F, 8'h22}, 78'h2));
        tbl.push_back(vv(OP_S0, 0, 0, {19'h1ABCD, 1'b0}, 8'h22, 0, xh(2, p0_29)));
        tbl.push_back(vv(OP_S1, 0, 0, {19'h1ABCD, 1'b1}, 8'h23, 0, 78'h0));
        tbl.push_back(vv(OP_S1, 0, 0, {19'h1ABCD, 1'b1}, 8'h22, 0, xh(2, p1_29)));
        tbl.push_back(vv(OP_R,  4'd9, 0, 0, 0, 0, e29));

        rst = 1;
        clr();
        bus.s0_vaddr = 0; bus.s0_asid = 0; bus.s1_vaddr = 0; bus.s1_asid = 0;
        bus.tlbp_entryhi = 0; bus.tlb_index = 0; bus.tlbwi_entry = 0;
        repeat (3) @(negedge clk);
        chk("reset_valids", 78'({bus.s0_rvalid, bus.s1_rvalid, bus.tlbp_wen, bus.tlbr_wen}), 78'h0);
        chk("reset_s0", 78'({bus.s0_found, bus.s0_index, bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v}), 78'h0);
        chk("reset_s1", 78'({bus.s1_found, bus.s1_index, bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v}), 78'h0);
        chk("reset_tlbp_index", 78'(bus.tlbp_index), 78'h0);
        chk("reset_tlbr_entry", bus.tlbr_entry, 78'h0);
        #1 rst = 0;

        foreach (tbl[i]) drv(tbl[i]);
        idle();
        @(negedge clk);
        chk("hold_s1", 78'({bus.s1_rvalid, bus.s1_found, bus.s1_index, bus.s1_pfn}), 78'({1'b0, 1'b1, 4'd2, 20'h55555}));
        chk("hold_tlbp", 78'({bus.tlbp_wen, bus.tlbp_index}), 78'({1'b0, 32'h2}));

        // Write idx7 while s0 and tlbr look at it: both must see the old contents.
        @(negedge clk); #1;
        bus.tlbwi_we = 1; bus.tlb_index = 4'd7; bus.tlbwi_entry = e7;
        bus.s0_req = 1; bus.s0_vaddr = {19'h07777, 1'b0}; bus.s0_asid = 8'h01;
        bus.tlbr_req = 1;
        q0.push_back('{due: cyc + 1, val: 78'h0});
        qr.push_back('{due: cyc + 1, val: 78'h0});
        @(negedge clk); #1;
        bus.tlbwi_we = 0;
        q0.push_back('{due: cyc + 1, val: xh(7, p0_7)});
        qr.push_back('{due: cyc + 1, val: e7});
        idle();

        // Reset in the middle of back-to-back s0 requests.
        drv(vv(OP_S0, 0, 0, 20'h00400, 8'h05, 0, xh(3, p0_3)));
        @(negedge clk); #1;
        rst = 1; bus.s0_req = 1;
        @(negedge clk);
        chk("rst_edge_s0_rvalid", 78'(bus.s0_rvalid), 78'd0);
        #1 rst = 0; clr();
        @(negedge clk);
        chk("post_rst_s0_rvalid", 78'(bus.s0_rvalid), 78'd0);
        chk("post_rst_s0_data", 78'({bus.s0_found, bus.s0_index, bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v}), 78'h0);
        drv(vv(OP_R,  4'd3, 0, 0, 0, 0, 78'h0));
        drv(vv(OP_R,  4'd9, 0, 0, 0, 0, 78'h0));
        drv(vv(OP_R,  4'd7, 0, 0, 0, 0, 78'h0));
        drv(vv(OP_S0, 0, 0, 20'h00400, 8'h05, 0, 78'h0));
        // A cleared entry is vpn2=0/asid=0, so VA 0 with ASID 0 hits index 0 with zero fields.
        drv(vv(OP_S1, 0, 0, 20'h00000, 8'h00, 0, xh(0, 25'h0)));
        drv(vv(OP_P,  0, 0, 0, 0, 32'h0040_0005, 78'h8000_0000));
        idle();
        repeat (2) @(negedge clk);

        chk("results_outstanding", 78'(q0.size() + q1.size() + qp.size() + qr.size()), 78'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
